// File: rtl/free_list_mp.sv
// free_list_mp: multi-port physical register free list for rename.
// Optional double-free check: define FREE_LIST_DBLFREE_CHK_EN.
module free_list_mp #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 2,
    localparam int PREG_W   = $clog2(PHYS_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ALLOC_W-1:0]        alloc_req,
    output logic [ALLOC_W*PREG_W-1:0] alloc_phys,
    output logic                      alloc_ok,
    input  logic [FREE_W-1:0]         free_en,
    input  logic [FREE_W*PREG_W-1:0]  free_phys,
    output logic [PREG_W:0]           free_count,
    output logic                      almost_empty,
    output logic                      dbl_free_err
);

    localparam logic [PHYS_REGS-1:0] RST_MASK =
        {PHYS_REGS{1'b1}} << ARCH_REGS;
    localparam logic [PREG_W:0] RST_CNT = (PREG_W+1)'(PHYS_REGS - ARCH_REGS);
    localparam logic [PREG_W:0] AE_THR  = (PREG_W+1)'(2 * ALLOC_W);

    logic [PHYS_REGS-1:0]      r_mask;
    logic [PREG_W:0]           r_count;
    logic                      r_ae;

    logic [PHYS_REGS-1:0]      w_avail;
    logic [PHYS_REGS-1:0]      w_mask_alloc;
    logic [PHYS_REGS-1:0]      w_set;
    logic [PHYS_REGS-1:0]      w_new;
    logic [PHYS_REGS-1:0]      w_mask_next;
    logic [ALLOC_W*PREG_W-1:0] w_tags;
    logic [PREG_W:0]           w_req_cnt;
    logic [PREG_W:0]           w_granted;
    logic [PREG_W:0]           w_freed;
    logic [PREG_W:0]           w_count_next;
    logic [PREG_W-1:0]         w_ftag;
    logic                      w_found;
    logic                      w_ok;
    logic                      w_dbl;

    // Pick lowest free tags for requesting slots in ascending slot order.
    always_comb begin
        w_avail   = r_mask;
        w_tags    = '0;
        w_req_cnt = '0;
        w_found   = 1'b0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_req[i]) begin
                w_req_cnt = w_req_cnt + 1'b1;
                w_found   = 1'b0;
                for (int k = 0; k < PHYS_REGS; k++) begin
                    if (!w_found && w_avail[k]) begin
                        w_tags[i*PREG_W +: PREG_W] = PREG_W'(k);
                        w_avail[k] = 1'b0;
                        w_found    = 1'b1;
                    end
                end
            end
        end
        w_ok         = (w_req_cnt <= r_count);
        w_granted    = w_ok ? w_req_cnt : '0;
        w_mask_alloc = w_ok ? w_avail : r_mask;
    end

    // Gather released tags; duplicates collapse onto one mask bit.
    always_comb begin
        w_set  = '0;
        w_dbl  = 1'b0;
        w_ftag = '0;
        for (int j = 0; j < FREE_W; j++) begin
            if (free_en[j]) begin
                w_ftag = free_phys[j*PREG_W +: PREG_W];
`ifdef FREE_LIST_DBLFREE_CHK_EN
                if (r_mask[w_ftag]) begin
                    w_dbl = 1'b1;
                end else begin
                    w_set[w_ftag] = 1'b1;
                end
`else
                w_set[w_ftag] = 1'b1;
`endif
            end
        end
        w_new   = w_set & ~r_mask;
        w_freed = '0;
        for (int k = 0; k < PHYS_REGS; k++) begin
            w_freed = w_freed + {{PREG_W{1'b0}}, w_new[k]};
        end
        w_mask_next  = w_mask_alloc | w_set;
        w_count_next = r_count - w_granted + w_freed;
    end

    // Mask, count and low-water flag update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask  <= RST_MASK;
            r_count <= RST_CNT;
            r_ae    <= (RST_CNT < AE_THR);
        end else begin
            r_mask  <= w_mask_next;
            r_count <= w_count_next;
            r_ae    <= (w_count_next < AE_THR);
        end
    end

`ifdef FREE_LIST_DBLFREE_CHK_EN
    logic r_dbl_err;

    // Sticky double-free flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbl_err <= 1'b0;
        end else if (w_dbl) begin
            r_dbl_err <= 1'b1;
        end
    end

    assign dbl_free_err = r_dbl_err;
`else
    assign dbl_free_err = 1'b0;
    logic w_unused;
    assign w_unused = w_dbl;
`endif

    assign alloc_phys   = w_tags;
    assign alloc_ok     = w_ok;
    assign free_count   = r_count;
    assign almost_empty = r_ae;

endmodule

// File: tb/tb_free_list_mp.sv
// tb_free_list_mp: table-driven vectors plus directed corner sequences.
module tb_free_list_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alloc_req;
    logic [11:0] alloc_phys;
    logic        alloc_ok;
    logic [1:0]  free_en;
    logic [11:0] free_phys;
    logic [6:0]  free_count;
    logic        almost_empty;
    logic        dbl_free_err;

    int checks = 0;
    int errors = 0;

    free_list_mp dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_phys   (alloc_phys),
        .alloc_ok     (alloc_ok),
        .free_en      (free_en),
        .free_phys    (free_phys),
        .free_count   (free_count),
        .almost_empty (almost_empty),
        .dbl_free_err (dbl_free_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] fen;
        logic [5:0] f0;
        logic [5:0] f1;
        logic       ok;
        logic [5:0] t0;
        logic [5:0] t1;
        logic [6:0] cnt;
        logic       ae;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] fen,
                         input logic [5:0] f0, input logic [5:0] f1);
        @(negedge clk);
        alloc_req = req;
        free_en   = fen;
        free_phys = {f1, f0};
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        alloc_req = 2'b00;
        free_en   = 2'b00;
        free_phys = '0;
        @(negedge clk);
        reset = 1'b0;
        #2;
    endtask

    logic exp_err;

    initial begin
`ifdef FREE_LIST_DBLFREE_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reset     = 1'b1;
        alloc_req = 2'b00;
        free_en   = 2'b00;
        free_phys = '0;

        //          req    fen    f0     f1     ok    t0     t1     cnt    ae
        tbl[0] = '{2'b11, 2'b00, 6'd0,  6'd0,  1'b1, 6'd32, 6'd33, 7'd32, 1'b0};
        tbl[1] = '{2'b01, 2'b00, 6'd0,  6'd0,  1'b1, 6'd34, 6'd0,  7'd30, 1'b0};
        tbl[2] = '{2'b10, 2'b00, 6'd0,  6'd0,  1'b1, 6'd0,  6'd35, 7'd29, 1'b0};
        tbl[3] = '{2'b00, 2'b01, 6'd33, 6'd0,  1'b1, 6'd0,  6'd0,  7'd28, 1'b0};
        tbl[4] = '{2'b11, 2'b00, 6'd0,  6'd0,  1'b1, 6'd33, 6'd36, 7'd29, 1'b0};
        tbl[5] = '{2'b00, 2'b11, 6'd10, 6'd10, 1'b1, 6'd0,  6'd0,  7'd27, 1'b0};
        tbl[6] = '{2'b01, 2'b10, 6'd0,  6'd3,  1'b1, 6'd10, 6'd0,  7'd28, 1'b0};
        tbl[7] = '{2'b11, 2'b00, 6'd0,  6'd0,  1'b1, 6'd3,  6'd37, 7'd28, 1'b0};
        tbl[8] = '{2'b01, 2'b01, 6'd33, 6'd0,  1'b1, 6'd38, 6'd0,  7'd26, 1'b0};
        tbl[9] = '{2'b01, 2'b00, 6'd0,  6'd0,  1'b1, 6'd33, 6'd0,  7'd26, 1'b0};

        do_reset();
        chk("rst_count", 32'(free_count), 32'd32);
        chk("rst_ae", 32'(almost_empty), 32'd0);
        chk("rst_err", 32'(dbl_free_err), 32'd0);

        foreach (tbl[v]) begin
            drive(tbl[v].req, tbl[v].fen, tbl[v].f0, tbl[v].f1);
            chk($sformatf("v%0d_ok", v), 32'(alloc_ok), 32'(tbl[v].ok));
            chk($sformatf("v%0d_t0", v), 32'(alloc_phys[5:0]), 32'(tbl[v].t0));
            chk($sformatf("v%0d_t1", v), 32'(alloc_phys[11:6]), 32'(tbl[v].t1));
            chk($sformatf("v%0d_cnt", v), 32'(free_count), 32'(tbl[v].cnt));
            chk($sformatf("v%0d_ae", v), 32'(almost_empty), 32'(tbl[v].ae));
        end
        drive(2'b00, 2'b00, 6'd0, 6'd0);
        chk("tbl_end_cnt", 32'(free_count), 32'd25);

        // Drain two per cycle down to empty.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(2'b11, 2'b00, 6'd0, 6'd0);
            chk($sformatf("drain%0d_ok", k), 32'(alloc_ok), 32'd1);
            chk($sformatf("drain%0d_cnt", k), 32'(free_count), 32'(32 - 2*k));
            chk($sformatf("drain%0d_ae", k), 32'(almost_empty),
                32'((32 - 2*k) < 4));
        end
        drive(2'b01, 2'b00, 6'd0, 6'd0);
        chk("empty_cnt", 32'(free_count), 32'd0);
        chk("empty_ae", 32'(almost_empty), 32'd1);
        chk("empty_ok", 32'(alloc_ok), 32'd0);
        // Full list: free tag 5 while requesting two.
        drive(2'b11, 2'b01, 6'd5, 6'd0);
        chk("full_free_ok", 32'(alloc_ok), 32'd0);
        chk("full_free_cnt", 32'(free_count), 32'd0);
        // Count one: two requests refused.
        drive(2'b11, 2'b00, 6'd0, 6'd0);
        chk("one_cnt", 32'(free_count), 32'd1);
        chk("one_ok2", 32'(alloc_ok), 32'd0);
        drive(2'b10, 2'b00, 6'd0, 6'd0);
        chk("one_cnt_kept", 32'(free_count), 32'd1);
        chk("one_ok1", 32'(alloc_ok), 32'd1);
        chk("one_t0", 32'(alloc_phys[5:0]), 32'd0);
        chk("one_t1", 32'(alloc_phys[11:6]), 32'd5);
        drive(2'b00, 2'b00, 6'd0, 6'd0);
        chk("last_cnt", 32'(free_count), 32'd0);
        chk("last_ae", 32'(almost_empty), 32'd1);

        // Release of a tag that is already free.
        do_reset();
        drive(2'b00, 2'b01, 6'd40, 6'd0);
        drive(2'b00, 2'b00, 6'd0, 6'd0);
        chk("dbl_cnt", 32'(free_count), 32'd32);
        chk("dbl_err", 32'(dbl_free_err), 32'(exp_err));
        drive(2'b11, 2'b00, 6'd0, 6'd0);
        chk("dbl_err_sticky", 32'(dbl_free_err), 32'(exp_err));
        chk("dbl_t0", 32'(alloc_phys[5:0]), 32'd32);

        // Reset in the middle of a drain.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 2'b00, 6'd0, 6'd0);
        end
        @(negedge clk);
        reset     = 1'b1;
        alloc_req = 2'b11;
        free_en   = 2'b01;
        free_phys = {6'd0, 6'd2};
        @(negedge clk);
        reset     = 1'b0;
        alloc_req = 2'b11;
        free_en   = 2'b00;
        #2;
        chk("mid_rst_cnt", 32'(free_count), 32'd32);
        chk("mid_rst_ae", 32'(almost_empty), 32'd0);
        chk("mid_rst_err", 32'(dbl_free_err), 32'd0);
        chk("mid_rst_t0", 32'(alloc_phys[5:0]), 32'd32);
        chk("mid_rst_t1", 32'(alloc_phys[11:6]), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
